// File: rtl/am29xx_pkg.sv
// am29xx_pkg
// Shared encodings for the Am2901-compatible ALU slice fields (source
// operand select I2:0, function I5:3, destination I8:6) plus a small helper
// used to tell arithmetic functions from logic functions.
package am29xx_pkg;

  // Operand source select (R,S pair) on I2:0
  localparam logic [2:0] SRC_AQ = 3'd0;
  localparam logic [2:0] SRC_AB = 3'd1;
  localparam logic [2:0] SRC_ZQ = 3'd2;
  localparam logic [2:0] SRC_ZB = 3'd3;
  localparam logic [2:0] SRC_ZA = 3'd4;
  localparam logic [2:0] SRC_DA = 3'd5;
  localparam logic [2:0] SRC_DQ = 3'd6;
  localparam logic [2:0] SRC_DZ = 3'd7;

  // ALU function on I5:3
  localparam logic [2:0] OP_ADD  = 3'd0;  // R + S + cin
  localparam logic [2:0] OP_SUBR = 3'd1;  // S + ~R + cin
  localparam logic [2:0] OP_SUBS = 3'd2;  // R + ~S + cin
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NOTRS = 3'd5;
  localparam logic [2:0] OP_EXOR = 3'd6;
  localparam logic [2:0] OP_EXNOR = 3'd7;

  // Destination control on I8:6
  localparam logic [2:0] DST_QREG  = 3'd0;
  localparam logic [2:0] DST_NOP   = 3'd1;
  localparam logic [2:0] DST_RAMA  = 3'd2;
  localparam logic [2:0] DST_RAMF  = 3'd3;
  localparam logic [2:0] DST_RAMQD = 3'd4;
  localparam logic [2:0] DST_RAMD  = 3'd5;
  localparam logic [2:0] DST_RAMQU = 3'd6;
  localparam logic [2:0] DST_RAMU  = 3'd7;

  // True for the three adder-based functions
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUBR) || (op == OP_SUBS);
  endfunction

endpackage

// File: rtl/am2901_slice.sv
// am2901_slice
// 4-bit Am2901-compatible ALU slice: 16x4 register file, Q register,
// operand source mux, 8-function ALU, destination/shift network.
// Ports:
//   clock, reset_n          rising-edge clock, synchronous active-low reset
//   din, a, b               D input, register file read addresses A and B
//   src, op, dest           microinstruction fields I2:0, I5:3, I8:6
//   cin                     carry in
//   q0_in/q3_in/ram0_in/ram3_in   shift-in pins
//   yout, cout, f0, f3, ovr       Y output and flags (combinational)
//   q0_out/q3_out/ram0_out/ram3_out  shift-out pins (combinational)
module am2901_slice
  import am29xx_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] din,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] src,
  input  logic [2:0] op,
  input  logic [2:0] dest,
  input  logic       cin,
  input  logic       q0_in,
  input  logic       q3_in,
  input  logic       ram0_in,
  input  logic       ram3_in,
  output logic [3:0] yout,
  output logic       cout,
  output logic       f0,
  output logic       f3,
  output logic       ovr,
  output logic       q0_out,
  output logic       q3_out,
  output logic       ram0_out,
  output logic       ram3_out
);

  logic [3:0] ram_r [16];
  logic [3:0] q_r;

  logic [3:0] a_s, b_s, r_s, s_s;
  logic [3:0] opa_s, opb_s, f_s;
  logic [3:0] lo_s;
  logic [1:0] hi_s;
  logic       c4_s, ovr_s;
  logic       ram_we_s, q_we_s;
  logic [3:0] ram_wd_s, q_wd_s;

  assign a_s = ram_r[a];
  assign b_s = ram_r[b];

  // Operand source mux selecting the R and S operands
  always_comb begin
    r_s = 4'h0;
    s_s = 4'h0;
    case (src)
      SRC_AQ:  begin r_s = a_s;  s_s = q_r;  end
      SRC_AB:  begin r_s = a_s;  s_s = b_s;  end
      SRC_ZQ:  begin r_s = 4'h0; s_s = q_r;  end
      SRC_ZB:  begin r_s = 4'h0; s_s = b_s;  end
      SRC_ZA:  begin r_s = 4'h0; s_s = a_s;  end
      SRC_DA:  begin r_s = din;  s_s = a_s;  end
      SRC_DQ:  begin r_s = din;  s_s = q_r;  end
      SRC_DZ:  begin r_s = din;  s_s = 4'h0; end
      default: begin r_s = 4'h0; s_s = 4'h0; end
    endcase
  end

  // ALU core; the adder is split at bit 3 so the carry into the sign bit is
  // available for the overflow flag
  always_comb begin
    opa_s = r_s;
    opb_s = s_s;
    f_s   = 4'h0;
    c4_s  = 1'b0;
    ovr_s = 1'b0;
    lo_s  = 4'h0;
    hi_s  = 2'b00;
    case (op)
      OP_SUBR: opa_s = ~r_s;
      OP_SUBS: opb_s = ~s_s;
      default: opa_s = r_s;
    endcase
    if (is_arith(op)) begin
      lo_s  = {1'b0, opa_s[2:0]} + {1'b0, opb_s[2:0]} + {3'b000, cin};
      hi_s  = {1'b0, opa_s[3]} + {1'b0, opb_s[3]} + {1'b0, lo_s[3]};
      f_s   = {hi_s[0], lo_s[2:0]};
      c4_s  = hi_s[1];
      ovr_s = hi_s[1] ^ lo_s[3];
    end else begin
      case (op)
        OP_OR:    f_s = r_s | s_s;
        OP_AND:   f_s = r_s & s_s;
        OP_NOTRS: f_s = ~r_s & s_s;
        OP_EXOR:  f_s = r_s ^ s_s;
        OP_EXNOR: f_s = ~(r_s ^ s_s);
        default:  f_s = 4'h0;
      endcase
    end
  end

  // Destination decode: Y select plus register file / Q write data
  always_comb begin
    yout     = f_s;
    ram_we_s = 1'b0;
    q_we_s   = 1'b0;
    ram_wd_s = f_s;
    q_wd_s   = f_s;
    case (dest)
      DST_QREG:  q_we_s = 1'b1;
      DST_NOP:   q_we_s = 1'b0;
      DST_RAMA:  begin yout = a_s; ram_we_s = 1'b1; end
      DST_RAMF:  ram_we_s = 1'b1;
      DST_RAMQD: begin
        ram_we_s = 1'b1;
        q_we_s   = 1'b1;
        ram_wd_s = {ram3_in, f_s[3:1]};
        q_wd_s   = {q3_in, q_r[3:1]};
      end
      DST_RAMD:  begin ram_we_s = 1'b1; ram_wd_s = {ram3_in, f_s[3:1]}; end
      DST_RAMQU: begin
        ram_we_s = 1'b1;
        q_we_s   = 1'b1;
        ram_wd_s = {f_s[2:0], ram0_in};
        q_wd_s   = {q_r[2:0], q0_in};
      end
      DST_RAMU:  begin ram_we_s = 1'b1; ram_wd_s = {f_s[2:0], ram0_in}; end
      default:   ram_we_s = 1'b0;
    endcase
  end

  // Register file and Q state, cleared by reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) ram_r[i] <= 4'h0;
      q_r <= 4'h0;
    end else begin
      if (ram_we_s) ram_r[b] <= ram_wd_s;
      if (q_we_s)   q_r <= q_wd_s;
    end
  end

  assign cout     = c4_s;
  assign ovr      = ovr_s;
  assign f0       = (f_s == 4'h0);
  assign f3       = f_s[3];
  assign ram0_out = f_s[0];
  assign ram3_out = f_s[3];
  assign q0_out   = q_r[0];
  assign q3_out   = q_r[3];

endmodule

// File: rtl/am2909_slice.sv
// am2909_slice
// 4-bit Am2909/Am2911-compatible microprogram sequencer slice: PC, address
// register, 4-deep stack with wrapping pointer, source mux and incrementer.
// Ports:
//   clock, reset_n         rising-edge clock, synchronous active-low reset
//   din, rin, orin         D, R and OR inputs (rin/orin unused when SEQ_2911=1)
//   s0, s1                 source select (0 PC, 1 AR, 2 stack top, 3 D)
//   zero_n                 low forces the address output to zero
//   cin                    incrementer carry in
//   re_n, fe_n, pup        AR load, stack enable, push/pop direction
//   yout, cout             microaddress and incrementer carry out
module am2909_slice #(
  parameter bit SEQ_2911 = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] din,
  input  logic [3:0] rin,
  input  logic [3:0] orin,
  input  logic       s0,
  input  logic       s1,
  input  logic       zero_n,
  input  logic       cin,
  input  logic       re_n,
  input  logic       fe_n,
  input  logic       pup,
  output logic [3:0] yout,
  output logic       cout
);

  logic [3:0] pc_r, ar_r;
  logic [1:0] sp_r;
  logic [3:0] stack_r [4];

  logic [3:0] mux_s, or_s, ar_d_s, y_s, inc_s;
  logic       co_s;
  logic [1:0] sp_up_s, sp_dn_s;

  // The 2911 shares one pin for D and R and has no OR inputs
  assign ar_d_s  = SEQ_2911 ? din : rin;
  assign or_s    = SEQ_2911 ? 4'h0 : orin;
  assign sp_up_s = sp_r + 2'd1;
  assign sp_dn_s = sp_r - 2'd1;

  // Address source mux, OR merge, zero force and incrementer
  always_comb begin
    mux_s = pc_r;
    case ({s1, s0})
      2'd0:    mux_s = pc_r;
      2'd1:    mux_s = ar_r;
      2'd2:    mux_s = stack_r[sp_r];
      2'd3:    mux_s = din;
      default: mux_s = pc_r;
    endcase
    if (zero_n) begin
      y_s = mux_s | or_s;
    end else begin
      y_s = 4'h0;
    end
    {co_s, inc_s} = {1'b0, y_s} + {4'h0, cin};
  end

  // PC, AR and stack state; a push stores the PC value from before this edge
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_r <= 4'h0;
      ar_r <= 4'h0;
      sp_r <= 2'd0;
      for (int i = 0; i < 4; i++) stack_r[i] <= 4'h0;
    end else begin
      pc_r <= inc_s;
      if (!re_n) ar_r <= ar_d_s;
      if (!fe_n) begin
        if (pup) begin
          sp_r <= sp_up_s;
          stack_r[sp_up_s] <= pc_r;
        end else begin
          sp_r <= sp_dn_s;
        end
      end
    end
  end

  assign yout = y_s;
  assign cout = co_s;

endmodule

// File: rtl/am29xx_slices.sv
// am29xx_slices
// Bit-slice kit: one Am2901-compatible ALU slice (alu_* ports) and one
// Am2909/Am2911-compatible sequencer slice (seq_* ports) sharing clock and
// synchronous active-low reset. SEQ_2911 selects the sequencer variant.
// All outputs are continuously driven.
module am29xx_slices
  import am29xx_pkg::*;
#(
  parameter bit SEQ_2911 = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] alu_din,
  input  logic [3:0] alu_a,
  input  logic [3:0] alu_b,
  input  logic [2:0] alu_src,
  input  logic [2:0] alu_op,
  input  logic [2:0] alu_dest,
  input  logic       alu_cin,
  input  logic       alu_q0_in,
  input  logic       alu_q3_in,
  input  logic       alu_ram0_in,
  input  logic       alu_ram3_in,
  output logic [3:0] alu_yout,
  output logic       alu_cout,
  output logic       alu_f0,
  output logic       alu_f3,
  output logic       alu_ovr,
  output logic       alu_q0_out,
  output logic       alu_q3_out,
  output logic       alu_ram0_out,
  output logic       alu_ram3_out,
  input  logic [3:0] seq_din,
  input  logic [3:0] seq_rin,
  input  logic [3:0] seq_orin,
  input  logic       seq_s0,
  input  logic       seq_s1,
  input  logic       seq_zero_n,
  input  logic       seq_cin,
  input  logic       seq_re_n,
  input  logic       seq_fe_n,
  input  logic       seq_pup,
  output logic [3:0] seq_yout,
  output logic       seq_cout
);

  am2901_slice u_alu (
    .clock    (clock),
    .reset_n  (reset_n),
    .din      (alu_din),
    .a        (alu_a),
    .b        (alu_b),
    .src      (alu_src),
    .op       (alu_op),
    .dest     (alu_dest),
    .cin      (alu_cin),
    .q0_in    (alu_q0_in),
    .q3_in    (alu_q3_in),
    .ram0_in  (alu_ram0_in),
    .ram3_in  (alu_ram3_in),
    .yout     (alu_yout),
    .cout     (alu_cout),
    .f0       (alu_f0),
    .f3       (alu_f3),
    .ovr      (alu_ovr),
    .q0_out   (alu_q0_out),
    .q3_out   (alu_q3_out),
    .ram0_out (alu_ram0_out),
    .ram3_out (alu_ram3_out)
  );

  am2909_slice #(.SEQ_2911(SEQ_2911)) u_seq (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (seq_din),
    .rin     (seq_rin),
    .orin    (seq_orin),
    .s0      (seq_s0),
    .s1      (seq_s1),
    .zero_n  (seq_zero_n),
    .cin     (seq_cin),
    .re_n    (seq_re_n),
    .fe_n    (seq_fe_n),
    .pup     (seq_pup),
    .yout    (seq_yout),
    .cout    (seq_cout)
  );

endmodule

// File: tb/tb_am29xx_slices.sv
// Testbench for am29xx_slices: directed scenarios plus randomized stimulus
// checked against a behavioural model built from plain integer arithmetic.
// A second instance runs the sequencer in Am2911 mode on the same inputs.
module tb_am29xx_slices;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] alu_din, alu_a, alu_b;
  logic [2:0] alu_src, alu_op, alu_dest;
  logic       alu_cin, alu_q0_in, alu_q3_in, alu_ram0_in, alu_ram3_in;
  logic [3:0] alu_yout;
  logic       alu_cout, alu_f0, alu_f3, alu_ovr;
  logic       alu_q0_out, alu_q3_out, alu_ram0_out, alu_ram3_out;
  logic [3:0] seq_din, seq_rin, seq_orin;
  logic       seq_s0, seq_s1, seq_zero_n, seq_cin, seq_re_n, seq_fe_n, seq_pup;
  logic [3:0] seq_yout;
  logic       seq_cout;

  logic [3:0] x_alu_yout;
  logic       x_alu_cout, x_alu_f0, x_alu_f3, x_alu_ovr;
  logic       x_q0_out, x_q3_out, x_ram0_out, x_ram3_out;
  logic [3:0] x_seq_yout;
  logic       x_seq_cout;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: ALU registers/Q, and two sequencers (0 = 2909, 1 = 2911)
  int m_regs [16];
  int m_q;
  int m_pc [2];
  int m_ar [2];
  int m_sp [2];
  int m_stk [2][4];

  always #5 clock = ~clock;

  am29xx_slices dut (
    .clock(clock), .reset_n(reset_n),
    .alu_din(alu_din), .alu_a(alu_a), .alu_b(alu_b),
    .alu_src(alu_src), .alu_op(alu_op), .alu_dest(alu_dest), .alu_cin(alu_cin),
    .alu_q0_in(alu_q0_in), .alu_q3_in(alu_q3_in),
    .alu_ram0_in(alu_ram0_in), .alu_ram3_in(alu_ram3_in),
    .alu_yout(alu_yout), .alu_cout(alu_cout), .alu_f0(alu_f0), .alu_f3(alu_f3),
    .alu_ovr(alu_ovr), .alu_q0_out(alu_q0_out), .alu_q3_out(alu_q3_out),
    .alu_ram0_out(alu_ram0_out), .alu_ram3_out(alu_ram3_out),
    .seq_din(seq_din), .seq_rin(seq_rin), .seq_orin(seq_orin),
    .seq_s0(seq_s0), .seq_s1(seq_s1), .seq_zero_n(seq_zero_n), .seq_cin(seq_cin),
    .seq_re_n(seq_re_n), .seq_fe_n(seq_fe_n), .seq_pup(seq_pup),
    .seq_yout(seq_yout), .seq_cout(seq_cout)
  );

  am29xx_slices #(.SEQ_2911(1'b1)) dut2911 (
    .clock(clock), .reset_n(reset_n),
    .alu_din(alu_din), .alu_a(alu_a), .alu_b(alu_b),
    .alu_src(alu_src), .alu_op(alu_op), .alu_dest(alu_dest), .alu_cin(alu_cin),
    .alu_q0_in(alu_q0_in), .alu_q3_in(alu_q3_in),
    .alu_ram0_in(alu_ram0_in), .alu_ram3_in(alu_ram3_in),
    .alu_yout(x_alu_yout), .alu_cout(x_alu_cout), .alu_f0(x_alu_f0), .alu_f3(x_alu_f3),
    .alu_ovr(x_alu_ovr), .alu_q0_out(x_q0_out), .alu_q3_out(x_q3_out),
    .alu_ram0_out(x_ram0_out), .alu_ram3_out(x_ram3_out),
    .seq_din(seq_din), .seq_rin(seq_rin), .seq_orin(seq_orin),
    .seq_s0(seq_s0), .seq_s1(seq_s1), .seq_zero_n(seq_zero_n), .seq_cin(seq_cin),
    .seq_re_n(seq_re_n), .seq_fe_n(seq_fe_n), .seq_pup(seq_pup),
    .seq_yout(x_seq_yout), .seq_cout(x_seq_cout)
  );

  // ---------------- reference model ----------------

  function automatic int sgn4(int v);
    return (v > 7) ? v - 16 : v;
  endfunction

  task automatic alu_eval(output int y, output int f, output int co, output int ov);
    int av, bv, r, s, x, z, sum, ss;
    av = m_regs[alu_a];
    bv = m_regs[alu_b];
    case (alu_src)
      3'd0: begin r = av;      s = m_q; end
      3'd1: begin r = av;      s = bv;  end
      3'd2: begin r = 0;       s = m_q; end
      3'd3: begin r = 0;       s = bv;  end
      3'd4: begin r = 0;       s = av;  end
      3'd5: begin r = alu_din; s = av;  end
      3'd6: begin r = alu_din; s = m_q; end
      default: begin r = alu_din; s = 0; end
    endcase
    co = 0;
    ov = 0;
    if (alu_op <= 3'd2) begin
      x = (alu_op == 3'd1) ? 15 - r : r;
      z = (alu_op == 3'd2) ? 15 - s : s;
      sum = x + z + int'(alu_cin);
      f = sum % 16;
      co = sum / 16;
      ss = sgn4(x) + sgn4(z) + int'(alu_cin);
      ov = (ss > 7 || ss < -8) ? 1 : 0;
    end else begin
      case (alu_op)
        3'd3: f = r | s;
        3'd4: f = r & s;
        3'd5: f = (15 - r) & s;
        3'd6: f = r ^ s;
        default: f = 15 - (r ^ s);
      endcase
    end
    y = (alu_dest == 3'd2) ? av : f;
  endtask

  task automatic alu_commit();
    int y, f, co, ov, qo;
    alu_eval(y, f, co, ov);
    qo = m_q;
    case (alu_dest)
      3'd0: m_q = f;
      3'd1: ;
      3'd2, 3'd3: m_regs[alu_b] = f;
      3'd4: begin m_regs[alu_b] = 8 * int'(alu_ram3_in) + f / 2; m_q = 8 * int'(alu_q3_in) + qo / 2; end
      3'd5: m_regs[alu_b] = 8 * int'(alu_ram3_in) + f / 2;
      3'd6: begin m_regs[alu_b] = (f * 2) % 16 + int'(alu_ram0_in); m_q = (qo * 2) % 16 + int'(alu_q0_in); end
      default: m_regs[alu_b] = (f * 2) % 16 + int'(alu_ram0_in);
    endcase
  endtask

  function automatic int seq_y(int k);
    int m, orv;
    case ({seq_s1, seq_s0})
      2'd0: m = m_pc[k];
      2'd1: m = m_ar[k];
      2'd2: m = m_stk[k][m_sp[k]];
      default: m = seq_din;
    endcase
    orv = (k == 1) ? 0 : int'(seq_orin);
    return seq_zero_n ? (m | orv) : 0;
  endfunction

  function automatic int seq_co(int k);
    return (seq_y(k) + int'(seq_cin)) / 16;
  endfunction

  task automatic seq_commit(int k);
    int y, oldpc;
    y = seq_y(k);
    oldpc = m_pc[k];
    m_pc[k] = (y + int'(seq_cin)) % 16;
    if (!seq_re_n) m_ar[k] = (k == 1) ? int'(seq_din) : int'(seq_rin);
    if (!seq_fe_n) begin
      if (seq_pup) begin
        m_sp[k] = (m_sp[k] + 1) % 4;
        m_stk[k][m_sp[k]] = oldpc;
      end else begin
        m_sp[k] = (m_sp[k] + 3) % 4;
      end
    end
  endtask

  // Advance one clock: model follows the edge, inputs change #1 later
  task automatic tick();
    @(posedge clock);
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 0;
      m_q = 0;
      for (int k = 0; k < 2; k++) begin
        m_pc[k] = 0; m_ar[k] = 0; m_sp[k] = 0;
        for (int j = 0; j < 4; j++) m_stk[k][j] = 0;
      end
    end else begin
      alu_commit();
      seq_commit(0);
      seq_commit(1);
    end
    #1;
  endtask

  task automatic idle_inputs();
    alu_din = 4'h0; alu_a = 4'h0; alu_b = 4'h0;
    alu_src = 3'd7; alu_op = 3'd0; alu_dest = 3'd1; alu_cin = 1'b0;
    alu_q0_in = 1'b0; alu_q3_in = 1'b0; alu_ram0_in = 1'b0; alu_ram3_in = 1'b0;
    seq_din = 4'h0; seq_rin = 4'h0; seq_orin = 4'h0;
    seq_s0 = 1'b0; seq_s1 = 1'b0; seq_zero_n = 1'b1; seq_cin = 1'b0;
    seq_re_n = 1'b1; seq_fe_n = 1'b1; seq_pup = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic set_alu(input logic [2:0] src, input logic [2:0] op, input logic [2:0] dest,
                         input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                         input logic cin);
    alu_src = src; alu_op = op; alu_dest = dest;
    alu_a = a; alu_b = b; alu_din = d; alu_cin = cin;
  endtask

  // ---------------- tests ----------------

  task automatic test_reset();
    // scribble some state first so the clear is visible
    idle_inputs();
    reset_n = 1'b1;
    set_alu(3'd7, 3'd0, 3'd3, 4'h0, 4'h9, 4'hF, 1'b0);
    tick();
    set_alu(3'd7, 3'd0, 3'd0, 4'h0, 4'h0, 4'h6, 1'b0);
    seq_re_n = 1'b0; seq_rin = 4'h7; seq_cin = 1'b1;
    tick();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_alu(3'd3, 3'd0, 3'd1, 4'h0, 4'(i), 4'h0, 1'b0);
      #2;
      n_tests++;
      if (alu_yout !== 4'h0 || alu_f0 !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got y=%h f0=%b, want y=0 f0=1", i, alu_yout, alu_f0);
      end
    end
    set_alu(3'd2, 3'd0, 3'd1, 4'h0, 4'h0, 4'h0, 1'b0);
    #2;
    n_tests++;
    if (alu_yout !== 4'h0 || alu_q0_out !== 1'b0 || alu_q3_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_q: got y=%h, want 0", alu_yout);
    end
    for (int s = 0; s < 3; s++) begin
      seq_s0 = s[0]; seq_s1 = s[1]; seq_cin = 1'b0;
      #1;
      n_tests++;
      if (seq_yout !== 4'h0 || seq_cout !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_seq_sel%0d: got y=%h co=%b, want 0 0", s, seq_yout, seq_cout);
      end
    end
  endtask

  task automatic test_alu_directed();
    do_reset();
    set_alu(3'd7, 3'd0, 3'd3, 4'h0, 4'h5, 4'hA, 1'b0);
    #2;
    n_tests++;
    if (alu_yout !== 4'hA || alu_f0 !== 1'b0 || alu_f3 !== 1'b1) begin
      n_fail++;
      $display("FAIL load_b5: got y=%h f0=%b f3=%b, want a 0 1", alu_yout, alu_f0, alu_f3);
    end
    tick();
    set_alu(3'd3, 3'd0, 3'd1, 4'h0, 4'h5, 4'h0, 1'b0);
    #2;
    n_tests++;
    if (alu_yout !== 4'hA) begin
      n_fail++;
      $display("FAIL read_b5: got %h, want a", alu_yout);
    end
    // R0 = 7, R1 = 1
    set_alu(3'd7, 3'd0, 3'd3, 4'h0, 4'h0, 4'h7, 1'b0); tick();
    set_alu(3'd7, 3'd0, 3'd3, 4'h0, 4'h1, 4'h1, 1'b0); tick();
    set_alu(3'd1, 3'd0, 3'd1, 4'h0, 4'h1, 4'h0, 1'b0);
    #2;
    n_tests++;
    if (alu_yout !== 4'h8 || alu_ovr !== 1'b1 || alu_cout !== 1'b0) begin
      n_fail++;
      $display("FAIL add_7_1: got y=%h ovr=%b co=%b, want 8 1 0", alu_yout, alu_ovr, alu_cout);
    end
    set_alu(3'd1, 3'd2, 3'd1, 4'h0, 4'h1, 4'h0, 1'b1);
    #2;
    n_tests++;
    if (alu_yout !== 4'h6 || alu_cout !== 1'b1 || alu_ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_7_1: got y=%h co=%b ovr=%b, want 6 1 0", alu_yout, alu_cout, alu_ovr);
    end
    // same-cycle write/read returns the old value
    set_alu(3'd3, 3'd0, 3'd3, 4'h0, 4'h1, 4'h0, 1'b1);
    #2;
    n_tests++;
    if (alu_yout !== 4'h2) begin
      n_fail++;
      $display("FAIL rmw_old: got %h, want 2", alu_yout);
    end
    tick();
    // R2 = 6, Q = 9, then shift down both
    set_alu(3'd7, 3'd0, 3'd3, 4'h0, 4'h2, 4'h6, 1'b0); tick();
    set_alu(3'd7, 3'd0, 3'd0, 4'h0, 4'h0, 4'h9, 1'b0); tick();
    set_alu(3'd3, 3'd0, 3'd4, 4'h0, 4'h2, 4'h0, 1'b0);
    alu_ram3_in = 1'b1; alu_q3_in = 1'b0;
    #2;
    n_tests++;
    if (alu_ram0_out !== 1'b0 || alu_q0_out !== 1'b1 || alu_ram3_out !== 1'b0 || alu_q3_out !== 1'b1) begin
      n_fail++;
      $display("FAIL shift_pins: got r0=%b q0=%b r3=%b q3=%b, want 0 1 0 1",
               alu_ram0_out, alu_q0_out, alu_ram3_out, alu_q3_out);
    end
    tick();
    alu_ram3_in = 1'b0;
    set_alu(3'd3, 3'd0, 3'd1, 4'h0, 4'h2, 4'h0, 1'b0);
    #2;
    n_tests++;
    if (alu_yout !== 4'hB) begin
      n_fail++;
      $display("FAIL shift_ram: got %h, want b", alu_yout);
    end
    set_alu(3'd2, 3'd0, 3'd1, 4'h0, 4'h0, 4'h0, 1'b0);
    #2;
    n_tests++;
    if (alu_yout !== 4'h4) begin
      n_fail++;
      $display("FAIL shift_q: got %h, want 4", alu_yout);
    end
  endtask

  task automatic test_alu_random();
    int y, f, co, ov;
    logic [3:0] pins, exp_pins;
    for (int n = 0; n < 400; n++) begin
      set_alu(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
              4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
              1'($urandom_range(1, 0)));
      alu_q0_in = 1'($urandom_range(1, 0)); alu_q3_in = 1'($urandom_range(1, 0));
      alu_ram0_in = 1'($urandom_range(1, 0)); alu_ram3_in = 1'($urandom_range(1, 0));
      #2;
      alu_eval(y, f, co, ov);
      pins = {alu_ram3_out, alu_ram0_out, alu_q3_out, alu_q0_out};
      exp_pins = {1'(f / 8), 1'(f % 2), 1'(m_q / 8), 1'(m_q % 2)};
      n_tests++;
      if (alu_yout !== 4'(y) || alu_cout !== 1'(co) || alu_ovr !== 1'(ov) ||
          alu_f0 !== (f == 0) || alu_f3 !== 1'(f / 8) || pins !== exp_pins) begin
        n_fail++;
        $display("FAIL alu_rand%0d: src=%0d op=%0d dst=%0d got y=%h co=%b ov=%b f0=%b f3=%b pins=%b, want y=%h co=%0d ov=%0d f=%h pins=%b",
                 n, alu_src, alu_op, alu_dest, alu_yout, alu_cout, alu_ovr, alu_f0, alu_f3, pins,
                 4'(y), co, ov, 4'(f), exp_pins);
      end
      tick();
    end
  endtask

  task automatic test_seq_count();
    do_reset();
    seq_cin = 1'b1;
    for (int i = 0; i < 17; i++) begin
      #2;
      n_tests++;
      if (seq_yout !== 4'(i % 16) || seq_cout !== (i == 15)) begin
        n_fail++;
        $display("FAIL seq_count%0d: got y=%h co=%b, want %h %b", i, seq_yout, seq_cout, 4'(i % 16), (i == 15));
      end
      tick();
    end
  endtask

  task automatic test_seq_stack();
    do_reset();
    seq_cin = 1'b1;
    tick(); tick(); tick();
    seq_fe_n = 1'b0; seq_pup = 1'b1;
    tick(); tick();
    seq_fe_n = 1'b1; seq_s1 = 1'b1; seq_s0 = 1'b0; seq_cin = 1'b0;
    #2;
    n_tests++;
    if (seq_yout !== 4'h4) begin
      n_fail++;
      $display("FAIL push_top: got %h, want 4", seq_yout);
    end
    seq_fe_n = 1'b0; seq_pup = 1'b0;
    tick();
    seq_fe_n = 1'b1;
    #2;
    n_tests++;
    if (seq_yout !== 4'h3) begin
      n_fail++;
      $display("FAIL pop_top: got %h, want 3", seq_yout);
    end
    // five pushes of PC 0..4 wrap the pointer onto slot 1
    do_reset();
    seq_cin = 1'b1; seq_fe_n = 1'b0; seq_pup = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    seq_fe_n = 1'b1; seq_s1 = 1'b1; seq_s0 = 1'b0; seq_cin = 1'b0;
    #2;
    n_tests++;
    if (seq_yout !== 4'h4) begin
      n_fail++;
      $display("FAIL wrap_top: got %h, want 4", seq_yout);
    end
    seq_fe_n = 1'b0; seq_pup = 1'b0;
    tick();
    seq_fe_n = 1'b1;
    #2;
    n_tests++;
    if (seq_yout !== 4'h3) begin
      n_fail++;
      $display("FAIL wrap_pop: got %h, want 3", seq_yout);
    end
  endtask

  task automatic test_seq_ar();
    do_reset();
    seq_re_n = 1'b0; seq_rin = 4'h9; seq_din = 4'h5;
    tick();
    seq_re_n = 1'b1; seq_s1 = 1'b0; seq_s0 = 1'b1; seq_orin = 4'h2;
    #2;
    n_tests++;
    if (seq_yout !== 4'hB || x_seq_yout !== 4'h5) begin
      n_fail++;
      $display("FAIL ar_or: got 2909=%h 2911=%h, want b 5", seq_yout, x_seq_yout);
    end
    seq_zero_n = 1'b0;
    #2;
    n_tests++;
    if (seq_yout !== 4'h0 || x_seq_yout !== 4'h0) begin
      n_fail++;
      $display("FAIL zero: got 2909=%h 2911=%h, want 0 0", seq_yout, x_seq_yout);
    end
    seq_zero_n = 1'b1;
  endtask

  task automatic test_seq_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      seq_din = 4'($urandom_range(15, 0)); seq_rin = 4'($urandom_range(15, 0));
      seq_orin = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'h0;
      seq_s0 = 1'($urandom_range(1, 0)); seq_s1 = 1'($urandom_range(1, 0));
      seq_zero_n = ($urandom_range(9, 0) != 0); seq_cin = 1'($urandom_range(1, 0));
      seq_re_n = 1'($urandom_range(1, 0)); seq_fe_n = 1'($urandom_range(1, 0));
      seq_pup = 1'($urandom_range(1, 0));
      #2;
      n_tests++;
      if (seq_yout !== 4'(seq_y(0)) || seq_cout !== 1'(seq_co(0)) ||
          x_seq_yout !== 4'(seq_y(1)) || x_seq_cout !== 1'(seq_co(1))) begin
        n_fail++;
        $display("FAIL seq_rand%0d: got y=%h co=%b y11=%h co11=%b, want %h %0d %h %0d",
                 n, seq_yout, seq_cout, x_seq_yout, x_seq_cout,
                 4'(seq_y(0)), seq_co(0), 4'(seq_y(1)), seq_co(1));
      end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    #1;
    tick();
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_seq_count();
    test_seq_stack();
    test_seq_ar();
    test_seq_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
